// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the bus generator and the receiver target.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 16;
   localparam int I2C_BYTES  = 2;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL and bus SDA into clk and flags SCL edges and START/STOP as
// registered 1-clk pulses, SYNC_STAGES+1 clk after the pin change; never stalls.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_smp,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_q;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // sda_smp is the delayed SDA, aligned with the edge flags it qualifies.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_q     <= 1'b1;
         sda_smp   <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_q     <= scl_s;
         sda_smp   <= sda_s;
         scl_rise  <= scl_s & ~scl_q;
         scl_fall  <= ~scl_s & scl_q;
         start_det <= scl_s & scl_q & sda_smp & ~sda_s;
         stop_det  <= scl_s & scl_q & ~sda_smp & sda_s;
      end
   end
endmodule

// File: rtl/i2c_receiver.sv
// Oversampled I2C target: decodes address + R/W, captures a 16-bit write word or
// returns a 16-bit read word; sda_in updates 1 clk after a detected SCL fall.
module i2c_receiver
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl,
   input  logic                  sda_out,
   input  logic                  sda_oe,
   input  logic [I2C_ADDR_W-1:0] i2c_addr_r,
   input  logic [I2C_DATA_W-1:0] rd_data_r,
   output logic                  sda_in,
   output logic [I2C_DATA_W-1:0] wr_data_r,
   output logic                  wr_valid,
   output logic                  busy
);
   logic                  sda_bus;
   logic                  sda_smp;
   logic                  scl_rise;
   logic                  scl_fall;
   logic                  start_det;
   logic                  stop_det;
   i2c_state_t            state;
   logic [I2C_DATA_W-1:0] shreg;
   logic [2:0]            bit_cnt;
   logic                  byte_idx;
   logic                  rnw;
   logic [7:0]            addr_byte;

   assign sda_bus   = (sda_oe ? sda_out : 1'b1) & sda_in;
   assign addr_byte = {shreg[6:0], sda_smp};

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda_bus),
      .sda_smp   (sda_smp),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // In both ACK states sda_in itself marks the phase: released = ACK not yet driven.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         byte_idx  <= 1'b0;
         rnw       <= 1'b0;
         sda_in    <= 1'b1;
         wr_data_r <= '0;
         wr_valid  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (stop_det) begin
            state  <= ST_IDLE;
            sda_in <= 1'b1;
            busy   <= 1'b0;
         end else if (start_det) begin
            state    <= ST_ADDR;
            bit_cnt  <= '0;
            byte_idx <= 1'b0;
            sda_in   <= 1'b1;
            busy     <= 1'b1;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shreg   <= {shreg[I2C_DATA_W-2:0], sda_smp};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (addr_byte[7:1] == i2c_addr_r) begin
                        state <= ST_ADDR_ACK;
                        rnw   <= addr_byte[0];
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_ADDR_ACK: if (scl_fall) begin
                  if (sda_in) begin
                     sda_in <= ACK;
                     shreg  <= rd_data_r;
                  end else if (rnw) begin
                     state  <= ST_RD_BYTE;
                     sda_in <= shreg[I2C_DATA_W-1];
                     shreg  <= {shreg[I2C_DATA_W-2:0], 1'b0};
                  end else begin
                     state  <= ST_WR_BYTE;
                     sda_in <= NACK;
                  end
               end
               ST_WR_BYTE: if (scl_rise) begin
                  shreg   <= {shreg[I2C_DATA_W-2:0], sda_smp};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_WR_ACK;
               end
               ST_WR_ACK: if (scl_fall) begin
                  if (sda_in) begin
                     sda_in <= ACK;
                  end else begin
                     sda_in <= NACK;
                     if (byte_idx) begin
                        wr_data_r <= shreg;
                        wr_valid  <= 1'b1;
                        state     <= ST_WAIT_STOP;
                     end else begin
                        byte_idx <= 1'b1;
                        state    <= ST_WR_BYTE;
                     end
                  end
               end
               ST_RD_BYTE: if (scl_fall) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     sda_in <= NACK;
                     state  <= ST_RD_ACK;
                  end else begin
                     sda_in <= shreg[I2C_DATA_W-1];
                     shreg  <= {shreg[I2C_DATA_W-2:0], 1'b0};
                  end
               end
               // byte_idx set on the ACK rise doubles as "next fall starts byte 1".
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_smp == ACK && !byte_idx) byte_idx <= 1'b1;
                     else                             state    <= ST_WAIT_STOP;
                  end else if (scl_fall && byte_idx) begin
                     state  <= ST_RD_BYTE;
                     sda_in <= shreg[I2C_DATA_W-1];
                     shreg  <= {shreg[I2C_DATA_W-2:0], 1'b0};
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_receiver.sv
// Bench for i2c_receiver: bus generator tasks, a vector table of whole
// transactions, hand-written timing/corner sequences and a wr_valid scoreboard.
module tb_i2c_receiver;
   import i2c_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl = 1'b1;
   logic        sda_out = 1'b1;
   logic        sda_oe = 1'b0;
   logic [6:0]  i2c_addr_r = 7'd94;
   logic [15:0] rd_data_r = 16'h0000;
   logic        sda_in;
   logic [15:0] wr_data_r;
   logic        wr_valid;
   logic        busy;
   logic        sda_bus;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] old_w;
      logic [15:0] new_w;
   } wr_exp_t;

   typedef struct {
      string       name;
      logic        rnw;
      logic [6:0]  gen_addr;
      logic [6:0]  tgt_addr;
      logic [15:0] data;
      logic        abort;
      int          exp_acks;
      int          exp_falls;
      logic        exp_wr;
      logic [15:0] exp_rd;
   } vec_t;

   wr_exp_t     wr_q[$];
   wr_exp_t     wr_e;
   vec_t        vecs[9];
   logic [15:0] model_wr = 16'h0000;
   logic [15:0] prev_wr = 16'h0000;
   logic        prev_sda = 1'b1;
   int          sda_falls = 0;

   i2c_receiver #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl        (scl),
      .sda_out    (sda_out),
      .sda_oe     (sda_oe),
      .i2c_addr_r (i2c_addr_r),
      .rd_data_r  (rd_data_r),
      .sda_in     (sda_in),
      .wr_data_r  (wr_data_r),
      .wr_valid   (wr_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign sda_bus = (sda_oe ? sda_out : 1'b1) & sda_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each wr_valid pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_valid) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_valid_unexpected: got pulse with word %0h, required no pulse", wr_data_r);
         end else begin
            wr_e = wr_q.pop_front();
            check("wr_valid_prev_word", {16'h0, prev_wr}, {16'h0, wr_e.old_w});
            check("wr_valid_new_word", {16'h0, wr_data_r}, {16'h0, wr_e.new_w});
         end
      end
      if (prev_sda && !sda_in) sda_falls++;
      prev_sda = sda_in;
      prev_wr  = wr_data_r;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic b);
      if (b) begin
         sda_oe = 1'b0;
      end else begin
         sda_oe  = 1'b1;
         sda_out = 1'b0;
      end
   endtask

   // Entered with SCL just driven low; leaves with SCL just driven low.
   task automatic bit_cycle(input logic b, output logic s);
      wait_clk(2); drv(b);
      wait_clk(6); scl = 1'b1;
      wait_clk(4); s = sda_bus;
      wait_clk(4); scl = 1'b0;
   endtask

   task automatic gen_start();
      drv(1'b1); scl = 1'b1;
      wait_clk(8); drv(1'b0);
      wait_clk(8); scl = 1'b0;
   endtask

   task automatic gen_rstart();
      wait_clk(2); drv(1'b1);
      wait_clk(6); scl = 1'b1;
      wait_clk(4); drv(1'b0);
      wait_clk(4); scl = 1'b0;
   endtask

   task automatic gen_stop();
      wait_clk(2); drv(1'b0);
      wait_clk(6); scl = 1'b1;
      wait_clk(4); drv(1'b1);
      wait_clk(8);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(v[i], s);
      bit_cycle(1'b1, ack);
   endtask

   task automatic recv_byte(input logic ack_bit, output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         v[i] = s;
      end
      bit_cycle(ack_bit, s);
   endtask

   task automatic run_vec(input vec_t v);
      int          acks;
      int          falls0;
      logic        a;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] rd_g;
      acks       = 0;
      falls0     = sda_falls;
      i2c_addr_r = v.tgt_addr;
      rd_data_r  = v.data;
      gen_start();
      check({v.name, "_busy_after_start"}, {31'h0, busy}, 32'h1);
      send_byte({v.gen_addr, v.rnw}, a);
      if (a == ACK) acks++;
      if (!v.rnw) begin
         if (v.exp_wr) begin
            wr_q.push_back('{model_wr, v.data});
            model_wr = v.data;
         end
         send_byte(v.data[15:8], a);
         if (a == ACK) acks++;
         if (!v.abort) begin
            send_byte(v.data[7:0], a);
            if (a == ACK) acks++;
         end
      end else begin
         recv_byte(ACK, b0);
         recv_byte(NACK, b1);
         rd_g = {b0, b1};
         check({v.name, "_rd_data_g"}, {16'h0, rd_g}, {16'h0, v.exp_rd});
      end
      gen_stop();
      check({v.name, "_acks"}, acks, v.exp_acks);
      if (v.exp_falls >= 0) check({v.name, "_sda_in_falls"}, sda_falls - falls0, v.exp_falls);
      check({v.name, "_wr_data_r"}, {16'h0, wr_data_r}, {16'h0, model_wr});
      check({v.name, "_busy_after_stop"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      logic        a;
      logic        s;
      logic [7:0]  ab;
      logic [7:0]  b0;
      logic [7:0]  b1;
      vec_t        post;

      //           name           rnw   gen     tgt     data      abort acks falls wr    rd
      vecs[0] = '{"wr_abc3",     1'b0, 7'd94,  7'd94,  16'hABC3, 1'b0, 3, 3,  1'b1, 16'h0000};
      vecs[1] = '{"rd_54ac",     1'b1, 7'd94,  7'd94,  16'h54AC, 1'b0, 1, -1, 1'b0, 16'h54AC};
      vecs[2] = '{"wr_mismatch", 1'b0, 7'd94,  7'd95,  16'h5A5A, 1'b0, 0, 0,  1'b0, 16'h0000};
      vecs[3] = '{"wr_abort",    1'b0, 7'd94,  7'd94,  16'hAB00, 1'b1, 2, 2,  1'b0, 16'h0000};
      vecs[4] = '{"wr_1234",     1'b0, 7'd94,  7'd94,  16'h1234, 1'b0, 3, 3,  1'b1, 16'h0000};
      vecs[5] = '{"rd_mismatch", 1'b1, 7'd94,  7'd95,  16'h54AC, 1'b0, 0, 0,  1'b0, 16'hFFFF};
      vecs[6] = '{"wr_addr7f",   1'b0, 7'h7F,  7'h7F,  16'h8001, 1'b0, 3, 3,  1'b1, 16'h0000};
      vecs[7] = '{"rd_addr00",   1'b1, 7'h00,  7'h00,  16'h0000, 1'b0, 1, -1, 1'b0, 16'h0000};
      vecs[8] = '{"wr_msb_diff", 1'b0, 7'h3F,  7'h7F,  16'hFFFF, 1'b0, 0, 0,  1'b0, 16'h0000};

      wait_clk(3);
      check("reset_sda_in", {31'h0, sda_in}, 32'h1);
      check("reset_wr_data_r", {16'h0, wr_data_r}, 32'h0);
      check("reset_wr_valid", {31'h0, wr_valid}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      rst = 1'b1;
      wait_clk(5);

      // START/ACK/STOP latencies measured clock by clock on a write of 0x0F0F.
      i2c_addr_r = 7'd94;
      drv(1'b1); scl = 1'b1;
      wait_clk(4); drv(1'b0);
      wait_clk(3); check("busy_start_lat3", {31'h0, busy}, 32'h0);
      wait_clk(1); check("busy_start_lat4", {31'h0, busy}, 32'h1);
      wait_clk(4); scl = 1'b0;
      ab = {7'd94, 1'b0};
      for (int i = 7; i >= 0; i--) bit_cycle(ab[i], s);
      wait_clk(2); drv(1'b1);
      wait_clk(1); check("ack_sda_in_lat3", {31'h0, sda_in}, 32'h1);
      wait_clk(1); check("ack_sda_in_lat4", {31'h0, sda_in}, 32'h0);
      wait_clk(4); scl = 1'b1;
      wait_clk(8); scl = 1'b0;
      wr_q.push_back('{model_wr, 16'h0F0F});
      model_wr = 16'h0F0F;
      send_byte(8'h0F, a); check("timing_ack_b0", {31'h0, a}, {31'h0, ACK});
      send_byte(8'h0F, a); check("timing_ack_b1", {31'h0, a}, {31'h0, ACK});
      wait_clk(2); drv(1'b0);
      wait_clk(6); scl = 1'b1;
      wait_clk(4); drv(1'b1);
      wait_clk(3); check("busy_stop_lat3", {31'h0, busy}, 32'h1);
      wait_clk(1); check("busy_stop_lat4", {31'h0, busy}, 32'h0);
      wait_clk(4);
      check("timing_wr_data_r", {16'h0, wr_data_r}, 32'h0F0F);

      for (int k = 0; k < 9; k++) run_vec(vecs[k]);

      // Repeated START after a write address ACK, then a read.
      i2c_addr_r = 7'd94;
      rd_data_r  = 16'h54AC;
      gen_start();
      send_byte({7'd94, 1'b0}, a); check("rs_wr_addr_ack", {31'h0, a}, {31'h0, ACK});
      gen_rstart();
      send_byte({7'd94, 1'b1}, a); check("rs_rd_addr_ack", {31'h0, a}, {31'h0, ACK});
      recv_byte(ACK, b0);
      recv_byte(NACK, b1);
      check("rs_rd_data_g", {16'h0, b0, b1}, 32'h54AC);
      gen_stop();
      check("rs_wr_data_r", {16'h0, wr_data_r}, {16'h0, model_wr});
      check("rs_busy_after_stop", {31'h0, busy}, 32'h0);

      // Reset pulsed while the target drives a 0 in byte 0 of a read.
      gen_start();
      send_byte({7'd94, 1'b1}, a); check("rst_addr_ack", {31'h0, a}, {31'h0, ACK});
      bit_cycle(1'b1, s); check("rst_rd_bit7", {31'h0, s}, 32'h0);
      bit_cycle(1'b1, s); check("rst_rd_bit6", {31'h0, s}, 32'h1);
      wait_clk(6);
      check("rst_sda_in_before", {31'h0, sda_in}, 32'h0);
      rst = 1'b0;
      #1;
      check("rst_sda_in_async", {31'h0, sda_in}, 32'h1);
      check("rst_busy_async", {31'h0, busy}, 32'h0);
      check("rst_wr_data_r_async", {16'h0, wr_data_r}, 32'h0);
      check("rst_wr_valid_async", {31'h0, wr_valid}, 32'h0);
      model_wr = 16'h0000;
      wait_clk(3);
      rst = 1'b1;
      drv(1'b1);
      wait_clk(4); scl = 1'b1;
      wait_clk(10);
      check("post_rst_busy_idle", {31'h0, busy}, 32'h0);
      check("post_rst_sda_in_idle", {31'h0, sda_in}, 32'h1);
      post = '{"post_rst_wr", 1'b0, 7'd94, 7'd94, 16'hC35A, 1'b0, 3, 3, 1'b1, 16'h0000};
      run_vec(post);
      post = '{"post_rst_rd", 1'b1, 7'd94, 7'd94, 16'h54AC, 1'b0, 1, -1, 1'b0, 16'h54AC};
      run_vec(post);

      wait_clk(5);
      check("scoreboard_empty", wr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
